// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC sequencer with return-address stack and RUN/HALT control
module pc_next_unit #(
  parameter int unsigned PC_INC      = 2,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in_i,
  input  logic [2:0]  pc_top_i,
  input  logic [12:0] imm_i,
  input  logic        step_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        cond_i,
  input  logic        jump_i,
  input  logic        call_i,
  input  logic        ret_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [15:0] next_pc_o,
  output logic        pc_write_o,
  output logic [3:0]  depth_o,
  output logic        stack_full_o,
  output logic        stack_empty_o,
  output logic        stack_err_o
);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic {RUN, HALT} state_e;
  state_e      state_q, state_d;
  logic [15:0] next_pc_q, next_pc_d;
  logic        pc_write_q, pc_write_d;
  logic [3:0]  depth_q, depth_d;
  logic        err_q, err_d;
  logic [15:0] stack_q [STACK_DEPTH];
  logic        accept, full, empty, do_ret, do_call, push, pop;
  logic [15:0] seq_pc, br_pc, abs_pc, top_entry;
  logic [AW-1:0] widx, ridx;
  assign full      = depth_q == 4'(STACK_DEPTH);
  assign empty     = depth_q == 4'd0;
  assign widx      = AW'(depth_q);
  assign ridx      = AW'(depth_q - 4'd1);
  assign seq_pc    = pc_in_i + 16'(PC_INC);
  assign br_pc     = pc_in_i + {{3{imm_i[12]}}, imm_i};
  assign abs_pc    = {pc_top_i, imm_i};
  assign top_entry = stack_q[ridx];
  // Command acceptance, priority decode and stack bookkeeping; Ret masks Call
  always_comb begin
    accept     = (state_q == RUN) && !stall_i && !halt_i && step_i;
    do_ret     = accept && ret_i;
    do_call    = accept && call_i && !ret_i;
    push       = do_call && !full;
    pop        = do_ret && !empty;
    pc_write_d = accept;
    next_pc_d  = !accept ? next_pc_q :
                 ret_i ? (empty ? seq_pc : top_entry) :
                 (call_i || jump_i) ? abs_pc :
                 (branch_i && cond_i) ? br_pc : seq_pc;
    depth_d    = push ? depth_q + 4'd1 : pop ? depth_q - 4'd1 : depth_q;
    err_d      = err_q || (do_ret && empty) || (do_call && full);
  end
  // RUN/HALT transitions; a stalled cycle holds the state, Halt beats Resume
  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      if (state_q == RUN)
        state_d = halt_i ? HALT : RUN;
      else
        state_d = (resume_i && !halt_i) ? RUN : HALT;
    end
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end
  // Registered outputs toward the PC register plus stack occupancy and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pc_q  <= '0;
      pc_write_q <= 1'b0;
      depth_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      next_pc_q  <= next_pc_d;
      pc_write_q <= pc_write_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
    end
  end
  // Return-address storage; pushed entry is the address after the call
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      stack_q[widx] <= seq_pc;
    end
  end
  assign next_pc_o     = next_pc_q;
  assign pc_write_o    = pc_write_q;
  assign depth_o       = depth_q;
  assign stack_full_o  = full;
  assign stack_empty_o = empty;
  assign stack_err_o   = err_q;
endmodule
